// File: rtl/demux_ctrl.sv
// demux_ctrl: routes a receive byte stream to four class FIFOs by the
// byte's top two bits, with backpressure, a destination mask and drop count.
module demux_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              INIT,
  input  logic [3:0]        CFG_ENABLE,
  input  logic              VALID,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic [3:0]        ALMOST_FULL,
  input  logic [3:0]        EMPTY,
  output logic [3:0]        PUSH,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              PAUSE,
  output logic              IDLE_OUT,
  output logic [CNT_W-1:0]  DROP_CNT,
  output logic [2:0]        STATE
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_PAUSE  = 3'd4
  } state_t;

  state_t     state;
  logic [3:0] mask;
  logic [1:0] sel;
  logic       fwd;
  logic       hit;
  logic       drop;
  logic       any_af;
  logic       any_busy;

  assign sel      = DATA_IN[DATA_W-1 -: 2];
  assign any_af   = |(ALMOST_FULL & mask);
  assign any_busy = |(~EMPTY & mask);

  // RESET and INIT never forward, so their valid bytes fall into drop
  assign fwd  = (state == S_IDLE) || (state == S_ACTIVE) ||
                (state == S_PAUSE);
  assign hit  = VALID && fwd && mask[sel];
  assign drop = VALID && !hit;

  assign PAUSE    = (state == S_PAUSE);
  assign IDLE_OUT = (state == S_IDLE);
  assign STATE    = state;

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state    <= S_RESET;
      mask     <= 4'h0;
      PUSH     <= 4'h0;
      DATA_OUT <= '0;
      DROP_CNT <= '0;
    end else begin
      PUSH <= hit ? (4'b0001 << sel) : 4'h0;
      if (hit)
        DATA_OUT <= DATA_IN;
      if (drop && (DROP_CNT != {CNT_W{1'b1}}))
        DROP_CNT <= DROP_CNT + CNT_W'(1);
      if (state == S_INIT)
        mask <= CFG_ENABLE;

      if (state == S_RESET)
        state <= S_INIT;
      else if (INIT)
        state <= S_INIT;
      else begin
        unique case (state)
          S_INIT:   state <= S_IDLE;
          S_IDLE: begin
            if (VALID || any_busy)
              state <= S_ACTIVE;
          end
          S_ACTIVE: begin
            if (any_af)
              state <= S_PAUSE;
            else if (!any_busy && !VALID)
              state <= S_IDLE;
          end
          S_PAUSE: begin
            if (!any_af)
              state <= S_ACTIVE;
          end
          default:  state <= S_RESET;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux_ctrl.sv
// tb_demux_ctrl: scoreboard bench for demux_ctrl (CNT_W=4 so the drop
// counter saturates quickly).
module tb_demux_ctrl;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RESET_L = 1'b0;
  logic          INIT = 1'b0;
  logic [3:0]    CFG_ENABLE = 4'h0;
  logic          VALID = 1'b0;
  logic [DW-1:0] DATA_IN = '0;
  logic [3:0]    ALMOST_FULL = 4'h0;
  logic [3:0]    EMPTY = 4'hF;
  logic [3:0]    PUSH;
  logic [DW-1:0] DATA_OUT;
  logic          PAUSE;
  logic          IDLE_OUT;
  logic [CW-1:0] DROP_CNT;
  logic [2:0]    STATE;

  demux_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .INIT(INIT),
    .CFG_ENABLE(CFG_ENABLE), .VALID(VALID), .DATA_IN(DATA_IN),
    .ALMOST_FULL(ALMOST_FULL), .EMPTY(EMPTY), .PUSH(PUSH),
    .DATA_OUT(DATA_OUT), .PAUSE(PAUSE), .IDLE_OUT(IDLE_OUT),
    .DROP_CNT(DROP_CNT), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]    push;
    logic [DW-1:0] dout;
    logic [CW-1:0] drops;
  } exp_t;

  exp_t   sb[$];
  int     n_chk = 0;
  int     n_err = 0;
  logic [3:0]    m_mask = 4'h0;
  logic          m_fwd = 1'b0;
  logic [DW-1:0] m_dout = '0;
  logic [CW-1:0] m_drop = '0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // drive one cycle, predict the result, compare after the edge
  task automatic cyc(input logic v, input logic [DW-1:0] d);
    exp_t       e;
    logic [1:0] s;
    s = d[DW-1 -: 2];
    e.push = 4'h0;
    if (v && m_fwd && m_mask[s]) begin
      e.push = 4'b0001 << s;
      m_dout = d;
    end else if (v && m_drop != 4'hF) begin
      m_drop = m_drop + 4'h1;
    end
    e.dout  = m_dout;
    e.drops = m_drop;
    sb.push_back(e);
    VALID   = v;
    DATA_IN = d;
    step();
    VALID = 1'b0;
    e = sb.pop_front();
    check("push", 32'(PUSH), 32'(e.push));
    check("dout", 32'(DATA_OUT), 32'(e.dout));
    check("drops", 32'(DROP_CNT), 32'(e.drops));
  endtask

  task automatic do_init(input logic [3:0] m);
    m_fwd = 1'b0;
    INIT = 1'b1;
    CFG_ENABLE = m;
    step();
    check("init_st1", 32'(STATE), 32'd1);
    step();
    check("init_st2", 32'(STATE), 32'd1);
    INIT = 1'b0;
    step();
    check("init_idle", 32'(STATE), 32'd2);
    check("init_idle_out", 32'(IDLE_OUT), 32'd1);
    m_mask = m;
    m_fwd = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_state", 32'(STATE), 32'd0);
    end
    check("rst_push", 32'(PUSH), 32'd0);
    check("rst_dout", 32'(DATA_OUT), 32'd0);
    check("rst_pause", 32'(PAUSE), 32'd0);
    check("rst_idle", 32'(IDLE_OUT), 32'd0);
    check("rst_drop", 32'(DROP_CNT), 32'd0);
    RESET_L = 1'b1;
    do_init(4'hF);

    // routing to all four classes
    cyc(1'b1, 8'h05);
    check("route_active", 32'(STATE), 32'd3);
    cyc(1'b1, 8'h45);
    cyc(1'b1, 8'h85);
    cyc(1'b1, 8'hC5);
    cyc(1'b0, 8'h00);
    check("route_idle", 32'(STATE), 32'd2);

    // disabled destinations drop
    do_init(4'b0101);
    cyc(1'b1, 8'h40);
    cyc(1'b1, 8'hC0);
    check("mask_drops", 32'(DROP_CNT), 32'd2);
    cyc(1'b1, 8'h80);
    cyc(1'b0, 8'h00);

    // backpressure, with a same-cycle byte to the full class
    do_init(4'hF);
    cyc(1'b1, 8'h05);
    ALMOST_FULL = 4'b0100;
    cyc(1'b1, 8'h80);
    check("bp_state", 32'(STATE), 32'd4);
    check("bp_pause", 32'(PAUSE), 32'd1);
    cyc(1'b1, 8'h80);
    check("bp_hold", 32'(STATE), 32'd4);
    ALMOST_FULL = 4'h0;
    cyc(1'b0, 8'h00);
    check("bp_rel_state", 32'(STATE), 32'd3);
    check("bp_rel_pause", 32'(PAUSE), 32'd0);
    cyc(1'b0, 8'h00);

    // almost-full of a disabled class is ignored
    do_init(4'b1011);
    cyc(1'b1, 8'h05);
    ALMOST_FULL = 4'b0100;
    cyc(1'b1, 8'h05);
    check("bp_mask_state", 32'(STATE), 32'd3);
    check("bp_mask_pause", 32'(PAUSE), 32'd0);
    ALMOST_FULL = 4'h0;
    cyc(1'b0, 8'h00);

    // saturation of the drop counter
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 8'h80);
    check("sat", 32'(DROP_CNT), 32'd15);
    cyc(1'b0, 8'h00);

    // reset in the middle of a push
    do_init(4'hF);
    VALID = 1'b1;
    DATA_IN = 8'hC5;
    step();
    VALID = 1'b0;
    check("mid_push", 32'(PUSH), 32'h8);
    #2;
    RESET_L = 1'b0;
    #1;
    check("mid_rst_push", 32'(PUSH), 32'd0);
    check("mid_rst_drop", 32'(DROP_CNT), 32'd0);
    check("mid_rst_state", 32'(STATE), 32'd0);
    m_mask = 4'h0;
    m_fwd = 1'b0;
    m_dout = '0;
    m_drop = '0;
    step();
    RESET_L = 1'b1;
    CFG_ENABLE = 4'hF;
    cyc(1'b1, 8'hC5);
    check("rel_init", 32'(STATE), 32'd1);
    cyc(1'b0, 8'h00);
    check("rel_idle", 32'(STATE), 32'd2);
    m_mask = 4'hF;
    m_fwd = 1'b1;
    cyc(1'b1, 8'hC5);
    cyc(1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
